// File: rtl/deferred_check_pkg.sv
// Shared types and helpers for the deferred signal checker.
package deferred_check_pkg;

   typedef struct packed {
      logic match;
      logic fail;
   } verdict_t;

   // Index width for a channel count; never narrower than one bit.
   function automatic int unsigned ch_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Saturating increment: holds at max rather than wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max,
                                           input logic inc);
      return (inc && (val != max)) ? val + 32'd1 : val;
   endfunction

endpackage

// File: rtl/deferred_check_ch.sv
// One checker channel: input sampling, stability count, verdict, sticky flag and fail counter.
// The optional don't-care mask is enabled by DEFERRED_CHECK_MASK_EN.
module deferred_check_ch
   import deferred_check_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned SETTLE = 2,
   parameter int unsigned CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] sig_in,
   input  logic [WIDTH-1:0] exp_in,
`ifdef DEFERRED_CHECK_MASK_EN
   input  logic [WIDTH-1:0] mask_in,
`endif
   input  logic             clr,
   output logic             match,
   output logic             fail,
   output logic             fail_sticky,
   output logic [CNT_W-1:0] fail_cnt
);

   localparam int unsigned         STAB_W   = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
   localparam logic [STAB_W-1:0]   STAB_MAX = STAB_W'(SETTLE);
   localparam logic [31:0]         CNT_MAX  = 32'({CNT_W{1'b1}});

   logic [WIDTH-1:0]  smp_q, exp_q;
   logic              en_q;
   logic [STAB_W-1:0] stab_q, stab_d;
   verdict_t          verdict_q, verdict_d;
   logic              sticky_q, sticky_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              eval, hit;
`ifdef DEFERRED_CHECK_MASK_EN
   logic [WIDTH-1:0]  mask_q;
`endif

   always_comb begin
      stab_d = '0;
      if (sig_in == smp_q) begin
         stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + STAB_W'(1);
      end
      eval = en_q && (stab_q == STAB_MAX);
`ifdef DEFERRED_CHECK_MASK_EN
      // Mask only relaxes the compare; stability still watches every bit.
      hit = ((smp_q ^ exp_q) & ~mask_q) == '0;
`else
      hit = (smp_q == exp_q);
`endif
      verdict_d.match = eval && hit;
      verdict_d.fail  = eval && !hit;
      // A fail arriving with clr is recorded rather than lost.
      sticky_d = clr ? verdict_q.fail : (sticky_q | verdict_q.fail);
      cnt_d    = clr ? CNT_W'(verdict_q.fail)
                     : CNT_W'(sat_inc(32'(cnt_q), CNT_MAX, verdict_q.fail));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         smp_q     <= '0;
         exp_q     <= '0;
         en_q      <= 1'b0;
         stab_q    <= '0;
         verdict_q <= '0;
         sticky_q  <= 1'b0;
         cnt_q     <= '0;
`ifdef DEFERRED_CHECK_MASK_EN
         mask_q    <= '0;
`endif
      end else begin
         smp_q     <= sig_in;
         exp_q     <= exp_in;
         en_q      <= en;
         stab_q    <= stab_d;
         verdict_q <= verdict_d;
         sticky_q  <= sticky_d;
         cnt_q     <= cnt_d;
`ifdef DEFERRED_CHECK_MASK_EN
         mask_q    <= mask_in;
`endif
      end
   end

   assign match       = verdict_q.match;
   assign fail        = verdict_q.fail;
   assign fail_sticky = sticky_q;
   assign fail_cnt    = cnt_q;

endmodule

// File: rtl/deferred_check_array.sv
// Multi-channel deferred signal checker with first-failing-channel capture.
// Define DEFERRED_CHECK_MASK_EN to add the per-bit don't-care mask input.
module deferred_check_array
   import deferred_check_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned SETTLE = 2,
   parameter int unsigned CNT_W  = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_CH-1:0]             en,
   input  logic [NUM_CH*WIDTH-1:0]       sig_in,
   input  logic [NUM_CH*WIDTH-1:0]       exp_in,
`ifdef DEFERRED_CHECK_MASK_EN
   input  logic [NUM_CH*WIDTH-1:0]       mask_in,
`endif
   input  logic                          clr,
   output logic [NUM_CH-1:0]             match,
   output logic [NUM_CH-1:0]             fail,
   output logic [NUM_CH-1:0]             fail_sticky,
   output logic [NUM_CH*CNT_W-1:0]       fail_cnt,
   output logic                          first_fail_vld,
   output logic [ch_idx_w(NUM_CH)-1:0]   first_fail_ch
);

   localparam int unsigned CH_W = ch_idx_w(NUM_CH);

   logic [CH_W-1:0] low_idx;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      deferred_check_ch #(
         .WIDTH  (WIDTH),
         .SETTLE (SETTLE),
         .CNT_W  (CNT_W)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .en          (en[i]),
         .sig_in      (sig_in[i*WIDTH +: WIDTH]),
         .exp_in      (exp_in[i*WIDTH +: WIDTH]),
`ifdef DEFERRED_CHECK_MASK_EN
         .mask_in     (mask_in[i*WIDTH +: WIDTH]),
`endif
         .clr         (clr),
         .match       (match[i]),
         .fail        (fail[i]),
         .fail_sticky (fail_sticky[i]),
         .fail_cnt    (fail_cnt[i*CNT_W +: CNT_W])
      );
   end

   // Lowest failing index wins; zero when nothing fails.
   always_comb begin
      low_idx = '0;
      for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
         if (fail[i]) low_idx = CH_W'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         first_fail_vld <= 1'b0;
         first_fail_ch  <= '0;
      end else if (clr || !first_fail_vld) begin
         first_fail_vld <= |fail;
         first_fail_ch  <= low_idx;
      end
   end

endmodule

// File: tb/tb_deferred_check_array.sv
// Directed bench for deferred_check_array: a 4-channel instance plus a 1-channel CNT_W=2 instance.
`timescale 1ns/1ps
module tb_deferred_check_array;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  en;
   logic [31:0] sig_in, exp_in;
   logic        clr;
   logic [3:0]  match, fail, fail_sticky;
   logic [31:0] fail_cnt;
   logic        first_fail_vld;
   logic [1:0]  first_fail_ch;

   logic        s_en;
   logic [7:0]  s_sig, s_exp;
   logic        s_clr;
   logic        s_match, s_fail, s_sticky;
   logic [1:0]  s_cnt;
   logic        s_vld;
   logic        s_ch;
`ifdef DEFERRED_CHECK_MASK_EN
   logic [31:0] mask_in;
   logic [7:0]  s_mask;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   deferred_check_array #(
      .NUM_CH (4), .WIDTH (8), .SETTLE (2), .CNT_W (8)
   ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .en             (en),
      .sig_in         (sig_in),
      .exp_in         (exp_in),
`ifdef DEFERRED_CHECK_MASK_EN
      .mask_in        (mask_in),
`endif
      .clr            (clr),
      .match          (match),
      .fail           (fail),
      .fail_sticky    (fail_sticky),
      .fail_cnt       (fail_cnt),
      .first_fail_vld (first_fail_vld),
      .first_fail_ch  (first_fail_ch)
   );

   deferred_check_array #(
      .NUM_CH (1), .WIDTH (8), .SETTLE (2), .CNT_W (2)
   ) u_sat (
      .clk            (clk),
      .rst_n          (rst_n),
      .en             (s_en),
      .sig_in         (s_sig),
      .exp_in         (s_exp),
`ifdef DEFERRED_CHECK_MASK_EN
      .mask_in        (s_mask),
`endif
      .clr            (s_clr),
      .match          (s_match),
      .fail           (s_fail),
      .fail_sticky    (s_sticky),
      .fail_cnt       (s_cnt),
      .first_fail_vld (s_vld),
      .first_fail_ch  (s_ch)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int ch, input logic [7:0] s, input logic [7:0] e);
      sig_in[ch*8 +: 8] = s;
      exp_in[ch*8 +: 8] = e;
   endtask

   initial begin
      rst_n  = 1'b0;
      en     = 4'h0;
      sig_in = 32'hDEAD_BEEF;
      exp_in = 32'h0;
      clr    = 1'b0;
      s_en   = 1'b0;
      s_sig  = 8'h0;
      s_exp  = 8'h0;
      s_clr  = 1'b0;
`ifdef DEFERRED_CHECK_MASK_EN
      mask_in = 32'h0;
      s_mask  = 8'h0;
`endif

      // Reset and idle
      tick(3);
      check("rst_match", match, 0);
      check("rst_fail", fail, 0);
      check("rst_sticky", fail_sticky, 0);
      check("rst_cnt", fail_cnt, 0);
      check("rst_ffvld", first_fail_vld, 0);
      check("rst_ffch", first_fail_ch, 0);
      check("rst_sat_cnt", s_cnt, 0);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick(1);
         check("idle_fail", {fail, s_fail}, 0);
      end
      check("idle_match", match, 0);
      check("idle_sticky", fail_sticky, 0);
      check("idle_ffvld", first_fail_vld, 0);

      // Latency: first match three edges after the inputs settle
      set_ch(0, 8'hA5, 8'hA5);
      en[0] = 1'b1;
      tick(3);
      check("lat_early", match[0], 0);
      tick(1);
      check("lat_match", match[0], 1);
      check("lat_nofail", fail[0], 0);

      // Glitch on ch1 suppresses verdicts
      en[1] = 1'b1;
      for (int k = 0; k < 6; k++) begin
         set_ch(1, (k % 2 == 1) ? 8'h3C : 8'h00, 8'h3C);
         tick(1);
         check("glitch_quiet", {match[1], fail[1]}, 0);
      end
      set_ch(1, 8'h00, 8'h3C);
      tick(3);
      check("glitch_settling", fail[1], 0);
      tick(1);
      check("glitch_fail", fail[1], 1);
      check("glitch_cnt0", fail_cnt[15:8], 0);
      tick(1);
      check("glitch_cnt1", fail_cnt[15:8], 1);
      tick(1);
      check("glitch_cnt2", fail_cnt[15:8], 2);
      check("glitch_ffvld", first_fail_vld, 1);
      check("glitch_ffch", first_fail_ch, 1);
      en[1] = 1'b0;
      tick(3);
      check("dis_nofail", fail[1], 0);
      check("dis_cnt", fail_cnt[15:8], 4);
      check("dis_sticky", fail_sticky, 4'b0010);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      check("clr1_sticky", fail_sticky, 0);
      check("clr1_cnt", fail_cnt, 0);
      check("clr1_ffvld", first_fail_vld, 0);

      // First-fail priority: ch2 and ch3 together, then ch0 later
      set_ch(2, 8'h11, 8'h22);
      set_ch(3, 8'h33, 8'h44);
      en[3:2] = 2'b11;
      tick(3);
      check("pri_early", fail[3:2], 0);
      tick(1);
      check("pri_fail", fail[3:2], 2'b11);
      check("pri_vld_lag", first_fail_vld, 0);
      tick(1);
      check("pri_vld", first_fail_vld, 1);
      check("pri_ch", first_fail_ch, 2);
      set_ch(0, 8'hA5, 8'h00);
      tick(1);
      check("exp_lag_match", match[0], 1);
      tick(1);
      check("ch0_fail", {match[0], fail[0]}, 2'b01);
      tick(1);
      check("pri_hold_ch", first_fail_ch, 2);
      check("pri_sticky", fail_sticky, 4'b1101);
      en = 4'h0;
      tick(2);
      check("pri_off", fail, 0);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      check("clr2_sticky", fail_sticky, 0);
      check("clr2_cnt", fail_cnt, 0);
      check("clr2_ffvld", first_fail_vld, 0);
      check("clr2_ffch", first_fail_ch, 0);

      // Saturation and clr/fail collision on the CNT_W=2 instance
      s_sig = 8'h05;
      s_exp = 8'h06;
      s_en  = 1'b1;
      tick(4);
      check("sat_fail", s_fail, 1);
      tick(5);
      check("sat_cnt", s_cnt, 3);
      check("sat_vld", s_vld, 1);
      check("sat_ch", s_ch, 0);
      s_clr = 1'b1;
      tick(1);
      s_clr = 1'b0;
      check("coll_cnt", s_cnt, 1);
      check("coll_sticky", s_sticky, 1);
      check("coll_vld", s_vld, 1);
      tick(1);
      check("coll_cnt_next", s_cnt, 2);

`ifdef DEFERRED_CHECK_MASK_EN
      // Masked low nibble turns a mismatch into a match
      mask_in[23:16] = 8'h0F;
      set_ch(2, 8'hA3, 8'hA7);
      en[2] = 1'b1;
      tick(4);
      check("mask_match", {match[2], fail[2]}, 2'b10);
      mask_in[23:16] = 8'h00;
      tick(2);
      check("nomask_fail", {match[2], fail[2]}, 2'b01);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
